// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared UART constants: FSM encodings, default baud timing and counter sizing.
// The receiver imports this package too.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_CLK_HZ       = 100_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
    localparam int UART_DATA_WIDTH   = 8;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Show-ahead FIFO read port: head word and empty flag from the FIFO, pop strobe back.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_ren;

    modport master (output fifo_empty, output fifo_data, input  fifo_ren);
    modport slave  (input  fifo_empty, input  fifo_data, output fifo_ren);
endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, tick marks the last cycle of a bit.
// clear holds the count at zero so a frame always starts on a full bit period.
module uart_baud_tick
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pulls words straight out of a show-ahead FIFO and sends
// start / DATA_WIDTH bits LSB first / stop, chaining frames with no idle gap.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_fifo_drain_if.slave   fifo,
    output logic                  tx,
    output logic                  busy
);
    localparam int            BW       = cnt_w(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  tx_d, busy_d;
    logic                  pop;
    logic                  tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  pop = !fifo.fifo_empty;
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA:  if (tick) begin
                shreg_d = shreg_q >> 1;
                if (bit_q == LAST_BIT) begin
                    state_d = STOP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            STOP:  if (tick) begin
                if (!fifo.fifo_empty) pop = 1'b1;
                else                  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pop from IDLE or the last stop cycle loads the next word directly.
        if (pop) begin
            state_d = START;
            shreg_d = fifo.fifo_data;
            bit_d   = '0;
        end
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign fifo.fifo_ren = pop && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule
